ecc_word_loader: RTL and testbench



---
 rtl/ecc_word_loader_pkg.sv | 28 ++
 rtl/ecc_word_unloader.sv | 53 +++++
 rtl/ecc_word_loader.sv | 151 +++++++++++++++
 tb/tb_ecc_word_loader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_word_loader_pkg.sv
// Shared constants for the ECC word loader: widths, FSM states, operand slots.
// Latency: n/a (declarations only).
// Backpressure: n/a. MAX_BITS must match the core's ECCDefine.v value.
package ecc_word_loader_pkg;

  localparam int MAX_BITS = 256;
  localparam int MAX_REG  = MAX_BITS - 1;
  localparam int WORD_W   = 32;

  // Point at infinity: the core encodes it as all-ones coordinates.
  localparam logic [MAX_REG:0] INF_COORD = '1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Operand load order on the input stream.
  localparam logic [2:0] OP_A  = 3'd0;
  localparam logic [2:0] OP_B  = 3'd1;
  localparam logic [2:0] OP_P  = 3'd2;
  localparam logic [2:0] OP_X1 = 3'd3;
  localparam logic [2:0] OP_Y1 = 3'd4;
  localparam logic [2:0] OP_N  = 3'd5;

endpackage

// File: rtl/ecc_word_unloader.sv
// Parallel-in/serial-out buffer for the result point, x then y, MS word first.
// Latency: first word valid the cycle after i_load.
// Backpressure: word held until i_out_ready; o_done marks the final handshake.
module ecc_word_unloader #(
  parameter int MAX_BITS = 256,
  parameter int WORD_W   = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [MAX_BITS-1:0] i_x,
  input  logic [MAX_BITS-1:0] i_y,
  output logic [WORD_W-1:0]   o_out_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_done
);

  localparam int TOTAL = 2 * (MAX_BITS / WORD_W);
  localparam int CNT_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [2*MAX_BITS-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  logic                  xfer;

  assign xfer       = o_out_valid && i_out_ready;
  assign o_done     = xfer && (cnt == LAST);
  assign o_out_data = shreg[2*MAX_BITS-1 -: WORD_W];

  // Capture the point, then rotate one word per handshake so the buffer
  // returns to the captured point once the last word has gone out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg       <= '1;
      cnt         <= '0;
      o_out_valid <= 1'b0;
    end else if (i_load) begin
      shreg       <= {i_x, i_y};
      cnt         <= '0;
      o_out_valid <= 1'b1;
    end else if (xfer) begin
      shreg <= {shreg[2*MAX_BITS-WORD_W-1:0], shreg[2*MAX_BITS-1 -: WORD_W]};
      if (cnt == LAST) begin
        cnt         <= '0;
        o_out_valid <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecc_word_loader.sv
// Word-serial operand loader / result unloader around the ECC scalar-mult core.
// Latency: last input word -> start 1 cycle; core finish -> first out word 1 cycle.
// Backpressure: input stalled outside LOAD; output held until i_out_ready. Option: ECC_ZERO_SCALAR_EN.
module ecc_word_loader #(
  parameter int MAX_BITS = ecc_word_loader_pkg::MAX_BITS,
  parameter int WORD_W   = ecc_word_loader_pkg::WORD_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [1:0]          i_mode,
  input  logic [WORD_W-1:0]   i_in_data,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  output logic [WORD_W-1:0]   o_out_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_busy,
  output logic [MAX_BITS-1:0] o_core_a,
  output logic [MAX_BITS-1:0] o_core_b,
  output logic [MAX_BITS-1:0] o_core_p,
  output logic [MAX_BITS-1:0] o_core_x1,
  output logic [MAX_BITS-1:0] o_core_y1,
  output logic [MAX_BITS-1:0] o_core_n,
  output logic [1:0]          o_core_mode,
  output logic                o_core_start,
  input  logic [MAX_BITS-1:0] i_core_x,
  input  logic [MAX_BITS-1:0] i_core_y,
  input  logic                i_core_finished
);

  import ecc_word_loader_pkg::*;

  localparam int WORDS = MAX_BITS / WORD_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  state_t              state, state_nxt;
  logic [2:0]          op_idx;
  logic [CNT_W-1:0]    word_cnt;
  logic                accept, last_word, scalar_zero, unload_start, unload_done;
  logic [MAX_BITS-1:0] res_x, res_y, in_word;

  assign accept    = i_in_valid && o_in_ready;
  assign last_word = (op_idx == OP_N) && (word_cnt == LAST_WORD);
  assign in_word   = MAX_BITS'(i_in_data);

`ifdef ECC_ZERO_SCALAR_EN
  // n as it will be once the word now being accepted has shifted in.
  logic [MAX_BITS-1:0] n_nxt;
  assign n_nxt       = (o_core_n << WORD_W) | in_word;
  assign scalar_zero = (n_nxt == '0);
`else
  assign scalar_zero = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  // Next state, handshake/strobe outputs and result source selection.
  always_comb begin
    state_nxt    = state;
    o_in_ready   = 1'b0;
    o_core_start = 1'b0;
    o_busy       = 1'b1;
    unload_start = 1'b0;
    res_x        = i_core_x;
    res_y        = i_core_y;
    case (state)
      ST_LOAD: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b0;
        if (accept && last_word) begin
          if (scalar_zero) begin
            // Zero scalar: answer is the point at infinity, core not started.
            unload_start = 1'b1;
            res_x        = '1;
            res_y        = '1;
            state_nxt    = ST_OUT;
          end else begin
            state_nxt = ST_START;
          end
        end
      end
      ST_START: begin
        o_core_start = 1'b1;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_core_finished) begin
          unload_start = 1'b1;
          state_nxt    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (unload_done) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Operand shift-in and load counters; only accepted words move anything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_idx      <= OP_A;
      word_cnt    <= '0;
      o_core_a    <= '0;
      o_core_b    <= '0;
      o_core_p    <= '0;
      o_core_x1   <= '0;
      o_core_y1   <= '0;
      o_core_n    <= '0;
      o_core_mode <= 2'b00;
    end else if (accept) begin
      if (op_idx == OP_A && word_cnt == '0) o_core_mode <= i_mode;
      case (op_idx)
        OP_A:    o_core_a  <= (o_core_a  << WORD_W) | in_word;
        OP_B:    o_core_b  <= (o_core_b  << WORD_W) | in_word;
        OP_P:    o_core_p  <= (o_core_p  << WORD_W) | in_word;
        OP_X1:   o_core_x1 <= (o_core_x1 << WORD_W) | in_word;
        OP_Y1:   o_core_y1 <= (o_core_y1 << WORD_W) | in_word;
        OP_N:    o_core_n  <= (o_core_n  << WORD_W) | in_word;
        default: ;
      endcase
      if (word_cnt == LAST_WORD) begin
        word_cnt <= '0;
        op_idx   <= last_word ? OP_A : op_idx + 3'd1;
      end else begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  ecc_word_unloader #(
    .MAX_BITS (MAX_BITS),
    .WORD_W   (WORD_W)
  ) u_unloader (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (unload_start),
    .i_x         (res_x),
    .i_y         (res_y),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_done      (unload_done)
  );

endmodule

// File: tb/tb_ecc_word_loader.sv
// Bench for ecc_word_loader with a stub core on y^2 = x^3 + 2x + 2 mod 17, P = (5,1).
// Scoreboard queue filled by the stimulus thread, drained by an output monitor.
// Output stalls are driven by a separate ready process.
module tb_ecc_word_loader;

  localparam int MB    = 32;
  localparam int WW    = 8;
  localparam int WORDS = MB / WW;

  typedef logic [5:0][MB-1:0] ops_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [1:0]    i_mode = 2'b00;
  logic [WW-1:0] i_in_data = '0;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [WW-1:0] o_out_data;
  logic          o_out_valid;
  logic          i_out_ready = 1'b1;
  logic          o_busy;
  logic [MB-1:0] o_core_a, o_core_b, o_core_p, o_core_x1, o_core_y1, o_core_n;
  logic [1:0]    o_core_mode;
  logic          o_core_start;
  logic [MB-1:0] i_core_x = '0;
  logic [MB-1:0] i_core_y = '0;
  logic          i_core_finished = 1'b0;

  int            n_checks = 0;
  int            n_errors = 0;
  int            start_cnt = 0;
  int            exp_start = 0;
  logic [WW-1:0] sb_q[$];
  bit            stall_en = 1'b0;
  bit            force_stall = 1'b0;
  bit            hold_pend = 1'b0;
  logic [WW-1:0] hold_dat = '0;

  ecc_word_loader #(.MAX_BITS(MB), .WORD_W(WW)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_mode          (i_mode),
    .i_in_data       (i_in_data),
    .i_in_valid      (i_in_valid),
    .o_in_ready      (o_in_ready),
    .o_out_data      (o_out_data),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_busy          (o_busy),
    .o_core_a        (o_core_a),
    .o_core_b        (o_core_b),
    .o_core_p        (o_core_p),
    .o_core_x1       (o_core_x1),
    .o_core_y1       (o_core_y1),
    .o_core_n        (o_core_n),
    .o_core_mode     (o_core_mode),
    .o_core_start    (o_core_start),
    .i_core_x        (i_core_x),
    .i_core_y        (i_core_y),
    .i_core_finished (i_core_finished)
  );

  always #5 i_clk = ~i_clk;

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic ops_t mk_ops(input logic [MB-1:0] a, b, p, x1, y1, n);
    ops_t o;
    o[0] = a; o[1] = b; o[2] = p; o[3] = x1; o[4] = y1; o[5] = n;
    return o;
  endfunction

  // Stub core: known multiples of P on the test curve, infinity otherwise.
  function automatic logic [2*MB-1:0] core_model(input logic [MB-1:0] n);
    case (n)
      32'd2:   return {32'd6, 32'd3};
      32'd3:   return {32'd10, 32'd6};
      default: return '1;
    endcase
  endfunction

  task automatic push_result(input logic [MB-1:0] x, input logic [MB-1:0] y);
    logic [2*MB-1:0] r;
    r = {x, y};
    for (int w = 2*WORDS-1; w >= 0; w--) sb_q.push_back(r[w*WW +: WW]);
  endtask

  task automatic do_load(input ops_t ops, input logic [1:0] mode, input bit gaps);
    for (int k = 0; k < 6; k++) begin
      for (int w = WORDS-1; w >= 0; w--) begin
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        while (!done) begin
          i_mode = ~mode;
          if (gaps && $urandom_range(0, 2) == 0) begin
            i_in_valid = 1'b0;
            i_in_data  = 8'hEE;
          end else begin
            i_in_valid = 1'b1;
            i_in_data  = ops[k][w*WW +: WW];
            if (k == 0 && w == WORDS-1) i_mode = mode;
            done = o_in_ready;
          end
          tick();
          guard++;
          if (!done && guard > 200) begin
            timeout_fail("load_accept");
            i_in_valid = 1'b0;
            return;
          end
        end
      end
    end
    i_in_valid = 1'b0;
    i_mode     = 2'b00;
  endtask

  task automatic run_core(input ops_t ops, input logic [1:0] mode, input bit stall_out);
    int guard;
    guard = 0;
    while (!o_core_start && guard < 100) begin
      tick();
      guard++;
    end
    if (!o_core_start) begin
      timeout_fail("core_start");
      return;
    end
    chkw("core_a", 64'(o_core_a), 64'(ops[0]));
    chkw("core_b", 64'(o_core_b), 64'(ops[1]));
    chkw("core_p", 64'(o_core_p), 64'(ops[2]));
    chkw("core_x1", 64'(o_core_x1), 64'(ops[3]));
    chkw("core_y1", 64'(o_core_y1), 64'(ops[4]));
    chkw("core_n", 64'(o_core_n), 64'(ops[5]));
    chkw("core_mode", 64'(o_core_mode), 64'(mode));
    chk1("busy_start", o_busy, 1'b1);
    tick();
    chk1("start_single", o_core_start, 1'b0);
    // Input offered while the core runs must be refused.
    i_in_valid = 1'b1;
    i_in_data  = 8'hAA;
    chk1("in_ready_wait", o_in_ready, 1'b0);
    repeat (3) tick();
    i_in_valid = 1'b0;
    chkw("a_stable_wait", 64'(o_core_a), 64'(ops[0]));
    chkw("n_stable_wait", 64'(o_core_n), 64'(ops[5]));
    chk1("no_out_in_wait", o_out_valid, 1'b0);
    if (stall_out) force_stall = 1'b1;
    {i_core_x, i_core_y} = core_model(o_core_n);
    i_core_finished = 1'b1;
    tick();
    i_core_finished = 1'b0;
    i_core_x = 32'h5A5A5A5A;
    i_core_y = 32'hA5A5A5A5;
    chk1("out_valid_latency", o_out_valid, 1'b1);
    if (stall_out) begin
      // Stray finish while unloading must not disturb the buffered result.
      i_core_x = 32'h12345678;
      i_core_y = 32'h9ABCDEF0;
      i_core_finished = 1'b1;
      tick();
      i_core_finished = 1'b0;
      repeat (2) tick();
      force_stall = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || o_busy) && guard < 500) begin
      tick();
      guard++;
    end
    if (sb_q.size() != 0 || o_busy) timeout_fail("drain");
    chk1("idle_out_valid", o_out_valid, 1'b0);
    chk1("idle_in_ready", o_in_ready, 1'b1);
    chkw("start_count", 64'(start_cnt), 64'(exp_start));
  endtask

  // Sink ready: random stalls when enabled, forced low on request.
  always @(posedge i_clk) begin
    #2;
    i_out_ready = force_stall ? 1'b0 : (stall_en ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  // Output monitor and start-pulse counter.
  always @(negedge i_clk) begin
    if (i_rst) begin
      hold_pend = 1'b0;
    end else begin
      if (o_core_start) start_cnt++;
      if (hold_pend) begin
        chk1("out_valid_hold", o_out_valid, 1'b1);
        chkw("out_data_hold", 64'(o_out_data), 64'(hold_dat));
      end
      if (o_out_valid && i_out_ready) begin
        if (sb_q.size() == 0) timeout_fail("out_unexpected_word");
        else chkw("out_word", 64'(o_out_data), 64'(sb_q.pop_front()));
        hold_pend = 1'b0;
      end else if (o_out_valid) begin
        hold_pend = 1'b1;
        hold_dat  = o_out_data;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ops_t ops;

    i_rst = 1'b1;
    repeat (3) tick();
    chk1("rst_in_ready", o_in_ready, 1'b1);
    chk1("rst_out_valid", o_out_valid, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_start", o_core_start, 1'b0);
    chkw("rst_core_a", 64'(o_core_a), 64'h0);
    chkw("rst_core_n", 64'(o_core_n), 64'h0);
    chkw("rst_core_mode", 64'(o_core_mode), 64'h0);
    i_rst = 1'b0;
    tick();

    // 2P = (6,3), no gaps, no stalls.
    ops = mk_ops(32'd2, 32'd2, 32'd17, 32'd5, 32'd1, 32'd2);
    push_result(32'd6, 32'd3);
    exp_start++;
    do_load(ops, 2'b00, 1'b0);
    run_core(ops, 2'b00, 1'b0);
    wait_idle();

    // 3P = (10,6) with input gaps and output stalls.
    stall_en = 1'b1;
    ops = mk_ops(32'd2, 32'd2, 32'd17, 32'd5, 32'd1, 32'd3);
    push_result(32'd10, 32'd6);
    exp_start++;
    do_load(ops, 2'b01, 1'b1);
    run_core(ops, 2'b01, 1'b0);
    wait_idle();

    // Stray finish pulse while idle in LOAD is ignored.
    i_core_x = 32'h77777777;
    i_core_y = 32'h77777777;
    i_core_finished = 1'b1;
    tick();
    i_core_finished = 1'b0;
    repeat (4) tick();
    chk1("fin_in_load_valid", o_out_valid, 1'b0);
    chk1("fin_in_load_busy", o_busy, 1'b0);

    // 2P again with a forced output stall and a stray finish during OUT.
    ops = mk_ops(32'd2, 32'd2, 32'd17, 32'd5, 32'd1, 32'd2);
    push_result(32'd6, 32'd3);
    exp_start++;
    do_load(ops, 2'b10, 1'b1);
    run_core(ops, 2'b10, 1'b1);
    wait_idle();

    // Partial load of 20 words, then reset: nothing of it may survive.
    stall_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = WW'(8'h30 + i);
      tick();
    end
    i_in_valid = 1'b0;
    i_rst = 1'b1;
    repeat (2) tick();
    chk1("midrst_busy", o_busy, 1'b0);
    chk1("midrst_in_ready", o_in_ready, 1'b1);
    chkw("midrst_core_a", 64'(o_core_a), 64'h0);
    chkw("midrst_core_y1", 64'(o_core_y1), 64'h0);
    i_rst = 1'b0;
    tick();
    ops = mk_ops(32'd2, 32'd2, 32'd17, 32'd5, 32'd1, 32'd2);
    push_result(32'd6, 32'd3);
    exp_start++;
    do_load(ops, 2'b11, 1'b0);
    run_core(ops, 2'b11, 1'b0);
    wait_idle();

    // Zero scalar: all-ones result either way; start pulses only without the option.
    ops = mk_ops(32'd2, 32'd2, 32'd17, 32'd5, 32'd1, 32'd0);
    push_result(32'hFFFFFFFF, 32'hFFFFFFFF);
    do_load(ops, 2'b00, 1'b0);
`ifdef ECC_ZERO_SCALAR_EN
    chk1("zero_no_start", o_core_start, 1'b0);
    chk1("zero_out_valid", o_out_valid, 1'b1);
`else
    exp_start++;
    run_core(ops, 2'b00, 1'b0);
`endif
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
